uart_rcv_fsm: RTL and testbench
===============================

// Module: uart_rcv_fsm
// PURPOSE
//  Serial receiver for the host command link (8N1, LSB first, idle high).
//  Samples RX mid-bit, assembles a byte, flags it with a rdy/clr_rdy handshake.
//  Sits in the Segway top level between the BLE RX pin and the Auth_blk command decode.
//  Receiving end of the UART_tx link the benches use to send 'g'/'s' commands.
// PARAMETERS
//  BAUD_CNT   2604  clocks per bit (50 MHz / 19200 baud); must be >= 8 and even
//  CNT_W      12    baud counter width; must satisfy 2**CNT_W > BAUD_CNT
// PORTS
//  clk       in   1  system clock, all logic on posedge
//  rst       in   1  synchronous, active-high reset
//  RX        in   1  asynchronous serial input, idle = 1
//  clr_rdy   in   1  consumer acknowledge; clears rdy, ovr_err, frm_err, par_err
//  rx_data   out  8  last good byte; held stable until the next good frame
//  rdy       out  1  rx_data valid; stays high until clr_rdy
//  frm_err   out  1  sticky; last frame had stop bit = 0
//  ovr_err   out  1  sticky; good byte completed while rdy was still 1
//  par_err   out  1  sticky parity error (only with UART_RCV_PARITY_EN, else tied 0)
// BEHAVIOUR
//  Reset: rx_data=8'h00, rdy=0, frm_err=0, ovr_err=0, par_err=0, state=IDLE.
//   The 2-flop RX synchroniser resets to 1. Reset mid-frame abandons the frame with no flags.
//  Arming: after reset, synced RX must be seen high for at least one cycle
//   before a falling edge counts. RX held low through reset is not a start bit.
//  States:
//   IDLE:   synced RX 1->0 while armed -> START; baud_cnt = BAUD_CNT/2.
//   START:  baud_cnt decrements. At 0, sample RX.
//           RX = 0 -> DATA; baud_cnt = BAUD_CNT; bit_cnt = 0.
//           RX = 1 -> glitch, back to IDLE, no flag change.
//   DATA:   at each baud_cnt 0, shift the sample into shift[7] (right shift) and reload.
//           After the 8th sample -> STOP (or PAR when the macro is defined).
//   PAR:    one sampled bit, then -> STOP.
//   STOP:   at baud_cnt 0, sample and go to IDLE in the same cycle.
//           Returning at mid-stop allows back-to-back frames.
//  Stop sample = 1 (good frame):
//   - rx_data <= shift and rdy <= 1, both on that same edge.
//   - frm_err <= 0.
//   - If rdy was already 1 and clr_rdy = 0 that cycle, ovr_err <= 1; new byte overwrites rx_data.
//  Stop sample = 0: frm_err <= 1; rx_data and rdy unchanged.
//  Simultaneous clr_rdy and good-frame completion: completion wins.
//   rdy stays 1, ovr_err not set, other sticky flags cleared except those set by this frame.
//  clr_rdy with no completion: rdy, frm_err, ovr_err, par_err <= 0 next edge.
//  Latency: rdy rises 2 (sync) + BAUD_CNT/2 + 9*BAUD_CNT (+BAUD_CNT with parity)
//   cycles after the RX falling edge, +/-1.
//  baud_cnt is CNT_W-bit unsigned and never wraps; reload happens on the cycle it reads 0.
//  No edge detection in START/DATA/PAR/STOP; RX transitions there are ignored except at samples.
// CONFIGURATION
//  `UART_RCV_PARITY_EN defined: 8E1 frames. The PAR state samples an even-parity bit.
//   On a good stop, if ^{shift, par_bit} != 0, par_err <= 1. Byte is still delivered (rdy = 1).
//  Not defined: 8N1. No PAR state; par_err is constant 0.
//   Frame length 10 bits; the PAR state and its logic are not synthesised.
// TESTING (bench uses BAUD_CNT=16 and UART_tx with matching baud)
//  1 Reset, send 8'h67 -> rdy=1 within 2+8+144+/-1 clk of the start edge, rx_data=8'h67, flags 0.
//     Then pulse clr_rdy -> rdy=0 next clk.
//  2 Send 8'h73 then 8'hA5 back-to-back with no clr_rdy -> rx_data=8'hA5, rdy=1, ovr_err=1.
//     Then clr_rdy -> all flags 0.
//  3 Force RX low for 5 clk mid-idle -> no rdy, no frm_err, state back to IDLE by clk 14.
//  4 Drive a frame of 8'h55 with the stop bit = 0 -> frm_err=1, rdy=0, rx_data keeps its old value.
//     Next good 8'h01 -> frm_err=0, rdy=1.
//  5 Assert rst at bit 4 of 8'hFF -> outputs 0 next clk.
//     Hold RX low through release: no frame until RX goes high, then a clean 8'h3C is received.
//  6 (PARITY_EN) 8'h07 with parity bit 0 -> rdy=1, par_err=1.
//     8'h07 with parity 1 -> par_err stays 0 after clr_rdy.

Source files
------------

// File: rtl/uart_rcv_fsm.sv
// uart_rcv_fsm: UART receiver, 8N1 by default or 8E1 when UART_RCV_PARITY_EN is defined.
// Mid-bit sampling, rdy/clr_rdy handshake, sticky framing/overrun/parity flags.
module uart_rcv_fsm #(
  parameter int BAUD_CNT = 2604,
  parameter int CNT_W    = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovr_err,
  output logic       par_err
);

  localparam int SYNC_STAGES = 2;

  // baud_cnt counts load..0 inclusive, so a load of N spans N+1 cycles. The half-bit
  // load also absorbs the synchroniser and edge-detect delay so samples land mid-bit.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_CNT / 2 - 2);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BAUD_CNT - 1);

`ifdef UART_RCV_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  localparam state_t AFTER_DATA = PAR;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam state_t AFTER_DATA = STOP;
`endif

  // ---------------------------------------------------------------------------
  // RX synchroniser. live_reg tracks which stages hold post-reset samples, so the
  // reset value of the chain can never arm the start-bit detector.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] live_reg;
  logic [SYNC_STAGES-1:0] sync_in;
  logic [SYNC_STAGES-1:0] live_in;

  assign sync_in = {sync_reg[SYNC_STAGES-2:0], RX};
  assign live_in = {live_reg[SYNC_STAGES-2:0], 1'b1};

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clk) begin
        if (rst) begin
          sync_reg[gi] <= 1'b1;
          live_reg[gi] <= 1'b0;
        end else begin
          sync_reg[gi] <= sync_in[gi];
          live_reg[gi] <= live_in[gi];
        end
      end
    end
  endgenerate

  logic rx_sync;
  logic rx_live;
  logic armed_reg;

  assign rx_sync = sync_reg[SYNC_STAGES-1];
  assign rx_live = live_reg[SYNC_STAGES-1];

  // armed_reg: the previous synced sample was a genuine high
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_reg <= 1'b0;
    end else begin
      armed_reg <= rx_live & rx_sync;
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t           state_reg,   state_next;
  logic [CNT_W-1:0] cnt_reg,     cnt_next;
  logic [2:0]       bit_cnt_reg, bit_cnt_next;
  logic [7:0]       shift_reg,   shift_next;
  logic [7:0]       rx_data_reg, rx_data_next;
  logic             rdy_reg,     rdy_next;
  logic             frm_err_reg, frm_err_next;
  logic             ovr_err_reg, ovr_err_next;
`ifdef UART_RCV_PARITY_EN
  logic             par_bit_reg, par_bit_next;
  logic             par_err_reg, par_err_next;
`endif

  logic cnt_zero;
  logic start_edge;
  logic stop_done;
  logic good_stop;
  logic bad_stop;

  assign cnt_zero   = (cnt_reg == '0);
  assign start_edge = armed_reg & ~rx_sync;
  assign stop_done  = (state_reg == STOP) && cnt_zero;
  assign good_stop  = stop_done & rx_sync;
  assign bad_stop   = stop_done & ~rx_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      rx_data_reg <= '0;
      rdy_reg     <= 1'b0;
      frm_err_reg <= 1'b0;
      ovr_err_reg <= 1'b0;
`ifdef UART_RCV_PARITY_EN
      par_bit_reg <= 1'b0;
      par_err_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      rx_data_reg <= rx_data_next;
      rdy_reg     <= rdy_next;
      frm_err_reg <= frm_err_next;
      ovr_err_reg <= ovr_err_next;
`ifdef UART_RCV_PARITY_EN
      par_bit_reg <= par_bit_next;
      par_err_reg <= par_err_next;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start_edge) state_next = START;
      START: if (cnt_zero) state_next = rx_sync ? IDLE : DATA;
      DATA:  if (cnt_zero && (bit_cnt_reg == 3'd7)) state_next = AFTER_DATA;
`ifdef UART_RCV_PARITY_EN
      PAR:   if (cnt_zero) state_next = STOP;
`endif
      STOP:  if (cnt_zero) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and flag logic
  // ---------------------------------------------------------------------------
`ifdef UART_RCV_PARITY_EN
  logic frame_par_err;
  assign frame_par_err = ^{shift_reg, par_bit_reg};
`endif

  always_comb begin
    cnt_next     = cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
`ifdef UART_RCV_PARITY_EN
    par_bit_next = par_bit_reg;
`endif

    if (state_reg == IDLE) begin
      if (start_edge) cnt_next = HALF_LOAD;
    end else if (!cnt_zero) begin
      cnt_next = cnt_reg - CNT_W'(1);
    end else begin
      cnt_next = BIT_LOAD;
      case (state_reg)
        START: bit_cnt_next = '0;
        DATA: begin
          shift_next   = {rx_sync, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
        end
`ifdef UART_RCV_PARITY_EN
        PAR:   par_bit_next = rx_sync;
`endif
        default: ;
      endcase
    end

    // A good completion beats a coincident clr_rdy; flags raised by this frame survive.
    rx_data_next = rx_data_reg;
    rdy_next     = rdy_reg;
    frm_err_next = frm_err_reg;
    ovr_err_next = ovr_err_reg;
`ifdef UART_RCV_PARITY_EN
    par_err_next = par_err_reg;
`endif
    if (good_stop) begin
      rx_data_next = shift_reg;
      rdy_next     = 1'b1;
      frm_err_next = 1'b0;
      ovr_err_next = clr_rdy ? 1'b0 : (ovr_err_reg | rdy_reg);
`ifdef UART_RCV_PARITY_EN
      par_err_next = (clr_rdy ? 1'b0 : par_err_reg) | frame_par_err;
`endif
    end else begin
      if (clr_rdy) begin
        rdy_next     = 1'b0;
        frm_err_next = 1'b0;
        ovr_err_next = 1'b0;
`ifdef UART_RCV_PARITY_EN
        par_err_next = 1'b0;
`endif
      end
      if (bad_stop) frm_err_next = 1'b1;
    end
  end

  assign rx_data = rx_data_reg;
  assign rdy     = rdy_reg;
  assign frm_err = frm_err_reg;
  assign ovr_err = ovr_err_reg;
`ifdef UART_RCV_PARITY_EN
  assign par_err = par_err_reg;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rcv_fsm.sv
// tb_uart_rcv_fsm: scoreboard bench for uart_rcv_fsm; a frame-level model predicts every
// output change and its cycle window, a monitor checks each change as it appears.
module tb_uart_rcv_fsm;

  localparam int B = 16;
`ifdef UART_RCV_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam bit PAR_ON     = 1'b1;
`else
  localparam int FRAME_BITS = 10;
  localparam bit PAR_ON     = 1'b0;
`endif
  // start edge to rdy: 2 sync cycles + half bit + remaining bits up to mid-stop
  localparam int LAT = 2 + B / 2 + (FRAME_BITS - 1) * B;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RX = 1'b1;
  logic       clr_rdy = 1'b0;
  logic [7:0] rx_data;
  logic       rdy, frm_err, ovr_err, par_err;

  uart_rcv_fsm #(.BAUD_CNT(B), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err),
    .ovr_err (ovr_err),
    .par_err (par_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] vec;   // {rx_data, rdy, frm_err, ovr_err, par_err}
    int          lo;
    int          hi;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [11:0] m_vec = '0;
  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b0;

  // Record the model's next output state; only real changes become expected events.
  task automatic expect_state(input logic [11:0] nv, input int lo, input int hi, input string tag);
    exp_t e;
    if (nv != m_vec) begin
      e.vec = nv;
      e.lo  = lo;
      e.hi  = hi;
      e.tag = tag;
      sb.push_back(e);
    end
    m_vec = nv;
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic pbit,
                            input string tag);
    logic [7:0] md;
    logic       mr, mf, mo, mp;
    int         c0;
    c0 = cyc;
    {md, mr, mf, mo, mp} = m_vec;
    if (stop_ok) begin
      mo = mo | mr;
      mr = 1'b1;
      md = d;
      mf = 1'b0;
      mp = mp | (PAR_ON & (^d ^ pbit));
    end else begin
      mf = 1'b1;
    end
    expect_state({md, mr, mf, mo, mp}, c0 + LAT - 1, c0 + LAT + 1, tag);
    RX = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      repeat (B) @(negedge clk);
    end
    if (PAR_ON) begin
      RX = pbit;
      repeat (B) @(negedge clk);
    end
    RX = stop_ok;
    repeat (B) @(negedge clk);
    RX = 1'b1;
  endtask

  task automatic pulse_clr(input string tag);
    expect_state({m_vec[11:4], 4'b0000}, cyc + 1, cyc + 1, tag);
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
  endtask

  // Monitor: every change on the outputs must match the head of the scoreboard.
  initial begin
    logic [11:0] prev_vec;
    logic [11:0] cur_vec;
    exp_t        e;
    wait (mon_en);
    prev_vec = {rx_data, rdy, frm_err, ovr_err, par_err};
    forever begin
      @(negedge clk);
      cur_vec = {rx_data, rdy, frm_err, ovr_err, par_err};
      if (cur_vec != prev_vec) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event act=%03h required=none cyc=%0d", cur_vec, cyc);
        end else begin
          e = sb.pop_front();
          $display("txn %-12s out=%03h exp=%03h cyc=%0d win=[%0d,%0d]",
                   e.tag, cur_vec, e.vec, cyc, e.lo, e.hi);
          if (cur_vec != e.vec) begin
            failures++;
            $display("FAIL %s value act=%03h required=%03h", e.tag, cur_vec, e.vec);
          end
          checks++;
          if (cyc < e.lo || cyc > e.hi) begin
            failures++;
            $display("FAIL %s timing act_cyc=%0d required=[%0d,%0d]", e.tag, cyc, e.lo, e.hi);
          end
        end
      end
      prev_vec = cur_vec;
    end
  end

  initial begin
    logic [7:0] d;
    logic       ok, p;
    int         gap;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({rx_data, rdy, frm_err, ovr_err, par_err} != 12'h000) begin
      failures++;
      $display("FAIL reset_state act=%03h required=000", {rx_data, rdy, frm_err, ovr_err, par_err});
    end
    mon_en = 1'b1;
    idle(5);

    // single byte, then acknowledge
    send_frame(8'h67, 1'b1, ^8'h67, "t1_67");
    idle(4);
    pulse_clr("t1_clr");
    idle(3);

    // back-to-back without acknowledge -> overrun
    send_frame(8'h73, 1'b1, ^8'h73, "t2_73");
    send_frame(8'hA5, 1'b1, ^8'hA5, "t2_a5_ovr");
    idle(4);
    pulse_clr("t2_clr");
    idle(3);

    // 5-cycle low glitch must not start a frame; a frame 14 clocks later must be clean
    RX = 1'b0;
    repeat (5) @(negedge clk);
    RX = 1'b1;
    repeat (9) @(negedge clk);
    send_frame(8'hC3, 1'b1, ^8'hC3, "t3_c3");
    idle(4);
    pulse_clr("t3_clr");
    idle(3);

    // framing error keeps old data, next good byte clears frm_err
    send_frame(8'h55, 1'b0, ^8'h55, "t4_55_frm");
    idle(4);
    send_frame(8'h01, 1'b1, ^8'h01, "t4_01");
    idle(4);

    // reset during bit 4 of 0xFF with RX held low through release
    RX = 1'b0;
    repeat (B) @(negedge clk);
    RX = 1'b1;
    repeat (4 * B + B / 2) @(negedge clk);
    expect_state(12'h000, cyc + 1, cyc + 1, "t5_rst");
    rst = 1'b1;
    RX  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    idle(20);
    send_frame(8'h3C, 1'b1, ^8'h3C, "t5_3c");
    idle(4);
    pulse_clr("t5_clr");
    idle(3);

`ifdef UART_RCV_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, "t6_par_bad");
    idle(4);
    pulse_clr("t6_clr1");
    idle(3);
    send_frame(8'h07, 1'b1, 1'b1, "t6_par_ok");
    idle(4);
    pulse_clr("t6_clr2");
    idle(3);
`endif

    // randomized frames, errors, gaps and acknowledges
    for (int i = 0; i < 14; i++) begin
      d  = 8'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      p  = (^d) ^ ($urandom_range(0, 4) == 0);
      send_frame(d, ok, p, $sformatf("rnd%0d", i));
      gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(2, 20);
      if (!ok && gap < 2) gap = 2;
      if (gap > 0) begin
        idle(gap);
        if ($urandom_range(0, 1) == 0) begin
          pulse_clr($sformatf("rnd%0d_clr", i));
          idle(2);
        end
      end
    end

    // drain with a bounded wait
    for (int w = 0; w < 20 * B && sb.size() != 0; w++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL pending_events act=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
